// File: rtl/video_timing_pkg.sv
// Default 640x480@60 raster timing constants and shared decode helpers.
package video_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_CW       = 10;

    localparam int VGA_H_TOTAL = VGA_H_SYNC + VGA_H_BACK + VGA_H_ACTIVE + VGA_H_FRONT;
    localparam int VGA_V_TOTAL = VGA_V_SYNC + VGA_V_BACK + VGA_V_ACTIVE + VGA_V_FRONT;
    localparam int VGA_HA0     = VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_VA0     = VGA_V_SYNC + VGA_V_BACK;

    // Half-open interval test [lo, hi).
    function automatic logic in_range(input int val, input int lo, input int hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/sync_axis.sv
// One raster axis: wrapping counter plus sync/active decode of its next value.
module sync_axis
    import video_timing_pkg::*;
#(
    parameter int TOTAL  = VGA_H_TOTAL,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int A0     = VGA_HA0,
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int CW     = VGA_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          nxt_sync,
    output logic          nxt_act,
    output logic [CW-1:0] nxt_pos
);

    logic [CW-1:0] nxt;

    assign wrap = en && (cnt == CW'(TOTAL - 1));

    always_comb begin
        nxt = cnt;
        if (wrap)
            nxt = '0;
        else if (en)
            nxt = cnt + 1'b1;
    end

    // Decode the value being loaded so flags line up with the counter.
    assign nxt_sync = in_range(int'(nxt), 0, SYNC);
    assign nxt_act  = in_range(int'(nxt), A0, A0 + ACTIVE);
    assign nxt_pos  = nxt - CW'(A0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= nxt;
    end

endmodule

// File: rtl/video_sync_gen.sv
// Free-running VGA raster timing: sync pulses, blanking, coordinates, strobes.
module video_sync_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE        = VGA_H_ACTIVE,
    parameter int H_FRONT         = VGA_H_FRONT,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BACK          = VGA_H_BACK,
    parameter int V_ACTIVE        = VGA_V_ACTIVE,
    parameter int V_FRONT         = VGA_V_FRONT,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BACK          = VGA_V_BACK,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int CW              = VGA_CW
) (
    input  logic          vga_clk,
    input  logic          reset,
    output logic          HS,
    output logic          VS,
    output logic          blank_n,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam logic ACT = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    logic          h_wrap;
    logic          v_wrap;
    logic          h_sync;
    logic          v_sync;
    logic          h_act;
    logic          v_act;
    logic          act;
    logic [CW-1:0] h_pos;
    logic [CW-1:0] v_pos;

    sync_axis #(
        .TOTAL  (H_TOTAL),
        .SYNC   (H_SYNC),
        .A0     (H_SYNC + H_BACK),
        .ACTIVE (H_ACTIVE),
        .CW     (CW)
    ) u_h (
        .clk      (vga_clk),
        .rst      (reset),
        .en       (1'b1),
        .cnt      (h_cnt),
        .wrap     (h_wrap),
        .nxt_sync (h_sync),
        .nxt_act  (h_act),
        .nxt_pos  (h_pos)
    );

    sync_axis #(
        .TOTAL  (V_TOTAL),
        .SYNC   (V_SYNC),
        .A0     (V_SYNC + V_BACK),
        .ACTIVE (V_ACTIVE),
        .CW     (CW)
    ) u_v (
        .clk      (vga_clk),
        .rst      (reset),
        .en       (h_wrap),
        .cnt      (v_cnt),
        .wrap     (v_wrap),
        .nxt_sync (v_sync),
        .nxt_act  (v_act),
        .nxt_pos  (v_pos)
    );

    assign act = h_act & v_act;

    // v_wrap implies h_wrap, so it marks the step onto the frame origin.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            HS          <= ACT;
            VS          <= ACT;
            blank_n     <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            HS          <= h_sync ? ACT : ~ACT;
            VS          <= v_sync ? ACT : ~ACT;
            blank_n     <= act;
            pixel_x     <= act ? h_pos : '0;
            pixel_y     <= act ? v_pos : '0;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

endmodule

// File: tb/tb_video_sync_gen.sv
// Scoreboard bench: default build plus a reduced raster in both sync polarities.
module tb_video_sync_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit low;
    } cfg_t;

    localparam int CW = 10;

    cfg_t c0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1};
    cfg_t c1 = '{8, 2, 3, 2, 5, 1, 2, 2, 1'b1};
    cfg_t c2 = '{8, 2, 3, 2, 5, 1, 2, 2, 1'b0};

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    logic hs0, vs0, bl0, ls0, fs0;
    logic hs1, vs1, bl1, ls1, fs1;
    logic hs2, vs2, bl2, ls2, fs2;
    logic [CW-1:0] h0, v0, x0, y0;
    logic [CW-1:0] h1, v1, x1, y1;
    logic [CW-1:0] h2, v2, x2, y2;

    video_sync_gen u0 (
        .vga_clk(clk), .reset(rst0), .HS(hs0), .VS(vs0), .blank_n(bl0),
        .h_cnt(h0), .v_cnt(v0), .pixel_x(x0), .pixel_y(y0),
        .line_start(ls0), .frame_start(fs0)
    );

    video_sync_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) u1 (
        .vga_clk(clk), .reset(rst1), .HS(hs1), .VS(vs1), .blank_n(bl1),
        .h_cnt(h1), .v_cnt(v1), .pixel_x(x1), .pixel_y(y1),
        .line_start(ls1), .frame_start(fs1)
    );

    video_sync_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE_LOW(0)
    ) u2 (
        .vga_clk(clk), .reset(rst1), .HS(hs2), .VS(vs2), .blank_n(bl2),
        .h_cnt(h2), .v_cnt(v2), .pixel_x(x2), .pixel_y(y2),
        .line_start(ls2), .frame_start(fs2)
    );

    logic [44:0] got0, got1, got2;
    assign got0 = {hs0, vs0, bl0, ls0, fs0, h0, v0, x0, y0};
    assign got1 = {hs1, vs1, bl1, ls1, fs1, h1, v1, x1, y1};
    assign got2 = {hs2, vs2, bl2, ls2, fs2, h2, v2, x2, y2};

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [44:0] expect_out(cfg_t c, int h, int v, bit r);
        logic a;
        logic bl;
        int px, py;
        a = c.low ? 1'b0 : 1'b1;
        if (r)
            return {a, a, 3'b000, 40'd0};
        bl = (h >= c.hs + c.hb) && (h < c.hs + c.hb + c.ha) &&
             (v >= c.vs + c.vb) && (v < c.vs + c.vb + c.va);
        px = bl ? h - (c.hs + c.hb) : 0;
        py = bl ? v - (c.vs + c.vb) : 0;
        return {(h < c.hs) ? a : ~a, (v < c.vs) ? a : ~a, bl,
                logic'(h == 0), logic'(h == 0 && v == 0),
                10'(h), 10'(v), 10'(px), 10'(py)};
    endfunction

    int mh[3] = '{0, 0, 0};
    int mv[3] = '{0, 0, 0};
    bit mr[3] = '{1'b1, 1'b1, 1'b1};

    task automatic adv(input int i, input cfg_t c, input logic r);
        int ht, vt;
        ht = c.hs + c.hb + c.ha + c.hf;
        vt = c.vs + c.vb + c.va + c.vf;
        if (r) begin
            mh[i] = 0; mv[i] = 0; mr[i] = 1'b1;
        end else begin
            mr[i] = 1'b0;
            mh[i]++;
            if (mh[i] == ht) begin
                mh[i] = 0;
                mv[i]++;
                if (mv[i] == vt) mv[i] = 0;
            end
        end
    endtask

    logic [44:0] q0[$], q1[$], q2[$];

    // Per-frame tallies on the reduced build, per-line tallies on the default build.
    bit f_on = 0;
    int f_hs, f_vs, f_bl, f_per;
    logic f_prev_hs = 1'b1;
    bit l_on = 0;
    int l_hs, l_per;

    task automatic cyc();
        @(posedge clk);
        adv(0, c0, rst0);
        adv(1, c1, rst1);
        adv(2, c2, rst1);
        q0.push_back(expect_out(c0, mh[0], mv[0], mr[0]));
        q1.push_back(expect_out(c1, mh[1], mv[1], mr[1]));
        q2.push_back(expect_out(c2, mh[2], mv[2], mr[2]));
        @(negedge clk);
        chk("d0", got0, q0.pop_front());
        chk("d1", got1, q1.pop_front());
        chk("d2_pol", got2, q2.pop_front());
        if (fs1) begin
            if (f_on) begin
                chk("frm_hs_pulses", f_hs, 10);
                chk("frm_vs_cyc", f_vs, 30);
                chk("frm_blank_cyc", f_bl, 40);
                chk("frm_period", f_per, 150);
            end
            f_on = 1; f_hs = 0; f_vs = 0; f_bl = 0; f_per = 0;
        end
        if (f_on) begin
            f_per++;
            if (!vs1) f_vs++;
            if (bl1) f_bl++;
            if (!hs1 && f_prev_hs) f_hs++;
        end
        f_prev_hs = hs1;
        if (ls0) begin
            if (l_on) begin
                chk("line_hs_low", l_hs, 96);
                chk("line_period", l_per, 800);
            end
            l_on = 1; l_hs = 0; l_per = 0;
        end
        if (l_on) begin
            l_per++;
            if (!hs0) l_hs++;
        end
    endtask

    initial begin
        repeat (5) cyc();
        chk("rst_h", h0, 0);
        chk("rst_sync", {hs0, vs0, bl0}, 3'b000);
        rst0 = 1'b0;
        rst1 = 1'b0;
        cyc();
        chk("rel_h", h0, 1);
        chk("rel_v", v0, 0);
        for (int n = 0; n < 40000 && !(h0 == 10'd799 && v0 == 10'd0); n++) cyc();
        cyc();
        chk("wrap_hv", {h0, v0}, {10'd0, 10'd1});
        for (int n = 0; n < 40000 && !(h0 == 10'd144 && v0 == 10'd35); n++) cyc();
        chk("first_px", {bl0, x0, y0}, {1'b1, 10'd0, 10'd0});
        for (int n = 0; n < 2000 && h0 != 10'd400; n++) cyc();
        chk("pre_rst", {bl0, x0, y0}, {1'b1, 10'd256, 10'd0});
        rst0 = 1'b1;
        l_on = 0;
        #1;
        chk("async_cnt", {h0, v0}, 20'd0);
        chk("async_flags", {hs0, vs0, bl0, ls0, fs0}, 5'b00000);
        chk("async_pix", {x0, y0}, 20'd0);
        repeat (3) cyc();
        rst0 = 1'b0;
        cyc();
        chk("restart_h", {h0, v0}, {10'd1, 10'd0});
        repeat (2500) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
